ts_rd_sched: RTL and testbench

- Rate scheduler that paces reads out of the TS output path (ts_buf plus idle-packet mux) toward the J.83 modulator.
- Drives ts_rd_req at a programmable average byte rate using a fractional phase accumulator (NCO).
- Groups requests into fixed-length packets and marks the first byte of each packet with ts_rd_sync.
- Sits between the channel-config register block and the TS output path, on clk_125m.

---
 rtl/ts_pkg.sv | 14 +
 rtl/ts_nco.sv | 30 +++
 rtl/ts_rd_sched.sv | 133 +++++++++++++
 tb/tb_ts_rd_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// Shared transport-stream constants and scheduler state encoding.
// Used by the TS output-path pacing logic.
package ts_pkg;

    localparam int         TS_PKT_LEN   = 188;
    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/ts_nco.sv
// Fractional phase accumulator: adds inc each enabled cycle, carry-out is the tick.
// Generic pacing primitive; clr restarts the phase at zero.
module ts_nco #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [ACC_W-1:0] inc,
    output logic             tick
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    assign sum  = {1'b0, acc} + {1'b0, inc};
    assign tick = en & sum[ACC_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/ts_rd_sched.sv
// TS read-rate scheduler: NCO-paced byte requests grouped into fixed-length packets,
// with shadowed rate changes applied only on packet boundaries.
module ts_rd_sched
    import ts_pkg::*;
#(
    parameter int U_DLY   = 1,
    parameter int PKT_LEN = TS_PKT_LEN,
    parameter int ACC_W   = 24,
    parameter int CNT_W   = 16
) (
    input  logic             clk_125m,
    input  logic             rst_125m,
    input  logic             sched_en,
    input  logic [ACC_W-1:0] rate_inc,
    input  logic             rate_load,
    output logic             ts_rd_sync,
    output logic             ts_rd_req,
    output logic             sched_busy,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             rate_chg_pend
);

    localparam int BCNT_W = $clog2(PKT_LEN);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(PKT_LEN - 1);

    // U_DLY only shapes behavioural models; these registers carry no delay.
    if (U_DLY < 0) begin : g_bad_dly
    end

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [ACC_W-1:0]  active_inc;
    logic [ACC_W-1:0]  shadow_inc;
    logic [ACC_W-1:0]  eff_inc;
    logic              pend;
    logic [BCNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0]  pkt_cnt_q;
    logic              carry_p0;
    logic              tick_p0;
    logic              req_p1;
    logic              last_req;
    logic              at_bound;
    logic              boundary;
    logic              copy_inc;
    logic              nco_run;
    logic              nco_clr;
    logic              halt;

    assign last_req = req_p1 && (byte_cnt == LAST_BYTE);
    assign at_bound = !req_p1 && (byte_cnt == '0);
    assign boundary = (state == ST_IDLE) || last_req;
    assign copy_inc = pend && boundary;
    assign eff_inc  = copy_inc ? shadow_inc : active_inc;
    assign nco_run  = (state != ST_IDLE);

    ts_nco #(
        .ACC_W (ACC_W)
    ) u_nco (
        .clk   (clk_125m),
        .rst_n (rst_125m),
        .en    (nco_run),
        .clr   (nco_clr),
        .inc   (active_inc),
        .tick  (carry_p0)
    );

    // A stop taken at a boundary also drops any carry of that cycle, so no
    // fresh packet can begin once the scheduler has returned to IDLE.
    always_comb begin
        state_nxt = state;
        nco_clr   = 1'b0;
        halt      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sched_en && (eff_inc != '0)) begin
                    state_nxt = ST_RUN;
                    nco_clr   = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (!sched_en && (last_req || at_bound)) begin
                    state_nxt = ST_IDLE;
                    halt      = 1'b1;
                end else if (!sched_en) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign tick_p0 = carry_p0 && !halt;

    // Stage p0 -> p1: carry becomes the registered byte request
    always_ff @(posedge clk_125m) begin
        if (!rst_125m) begin
            state      <= ST_IDLE;
            req_p1     <= 1'b0;
            byte_cnt   <= '0;
            pkt_cnt_q  <= '0;
            active_inc <= '0;
            shadow_inc <= '0;
            pend       <= 1'b0;
        end else begin
            state  <= state_nxt;
            req_p1 <= tick_p0;
            if (req_p1) begin
                byte_cnt <= last_req ? '0 : byte_cnt + 1'b1;
            end
            if (ts_rd_sync) begin
                pkt_cnt_q <= pkt_cnt_q + 1'b1;
            end
            if (copy_inc) begin
                active_inc <= shadow_inc;
            end
            if (rate_load) begin
                shadow_inc <= rate_inc;
                pend       <= 1'b1;
            end else if (copy_inc) begin
                pend <= 1'b0;
            end
        end
    end

    assign ts_rd_req     = req_p1;
    assign ts_rd_sync    = req_p1 && (byte_cnt == '0);
    assign sched_busy    = (byte_cnt != '0) || (state == ST_DRAIN);
    assign pkt_cnt       = pkt_cnt_q;
    assign rate_chg_pend = pend;

endmodule

// File: tb/tb_ts_rd_sched.sv
// Directed bench for ts_rd_sched: pacing, packet framing, rate shadowing,
// drain-on-stop, reset abort and near-full-rate operation.
module tb_ts_rd_sched;

    logic        clk_125m = 1'b0;
    logic        rst_125m;
    logic        sched_en;
    logic [23:0] rate_inc;
    logic        rate_load;
    logic        ts_rd_sync;
    logic        ts_rd_req;
    logic        sched_busy;
    logic [15:0] pkt_cnt;
    logic        rate_chg_pend;

    int checks   = 0;
    int failures = 0;

    int cyc       = 0;
    int req_seen  = 0;
    int sync_seen = 0;
    int last_sync = 0;
    int have_last = 0;
    int gap_min   = 1000000;
    int gap_max   = 0;

    ts_rd_sched #(
        .U_DLY   (1),
        .PKT_LEN (188),
        .ACC_W   (24),
        .CNT_W   (16)
    ) dut (
        .clk_125m      (clk_125m),
        .rst_125m      (rst_125m),
        .sched_en      (sched_en),
        .rate_inc      (rate_inc),
        .rate_load     (rate_load),
        .ts_rd_sync    (ts_rd_sync),
        .ts_rd_req     (ts_rd_req),
        .sched_busy    (sched_busy),
        .pkt_cnt       (pkt_cnt),
        .rate_chg_pend (rate_chg_pend)
    );

    always #4 clk_125m = ~clk_125m;

    always @(negedge clk_125m) begin
        cyc = cyc + 1;
        if (ts_rd_req === 1'b1) req_seen = req_seen + 1;
        if (ts_rd_sync === 1'b1) begin
            sync_seen = sync_seen + 1;
            if (have_last != 0) begin
                if (cyc - last_sync < gap_min) gap_min = cyc - last_sync;
                if (cyc - last_sync > gap_max) gap_max = cyc - last_sync;
            end
            have_last = 1;
            last_sync = cyc;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk_125m);
        #1;
    endtask

    task automatic mon_clear();
        req_seen  = 0;
        sync_seen = 0;
        have_last = 0;
        gap_min   = 1000000;
        gap_max   = 0;
    endtask

    task automatic do_reset();
        rst_125m  = 1'b0;
        sched_en  = 1'b0;
        rate_load = 1'b0;
        rate_inc  = 24'h0;
        tick_n(2);
    endtask

    initial begin
        do_reset();
        tick_n(1);
        chk("rst_req", ts_rd_req, 1'b0);
        chk("rst_sync", ts_rd_sync, 1'b0);
        chk("rst_busy", sched_busy, 1'b0);
        chk("rst_pkt_cnt", pkt_cnt, 16'd0);
        chk("rst_pend", rate_chg_pend, 1'b0);

        // Half rate: request every other cycle, 376 cycles per packet
        rst_125m  = 1'b1;
        rate_inc  = 24'h800000;
        rate_load = 1'b1;
        sched_en  = 1'b1;
        mon_clear();
        tick_n(1);
        rate_load = 1'b0;
        chk("half_pend_set", rate_chg_pend, 1'b1);
        chk("half_busy_idle", sched_busy, 1'b0);
        tick_n(1);
        chk("half_pend_clr", rate_chg_pend, 1'b0);
        tick_n(2);
        chk("half_first_req", ts_rd_req, 1'b1);
        chk("half_first_sync", ts_rd_sync, 1'b1);
        tick_n(1);
        chk("half_gap_req", ts_rd_req, 1'b0);
        chk("half_pkt_cnt1", pkt_cnt, 16'd1);
        chk("half_busy", sched_busy, 1'b1);
        tick_n(751);
        chk("half_sync3", ts_rd_sync, 1'b1);
        chk("half_pkt_cnt2", pkt_cnt, 16'd2);
        tick_n(1);
        chk("half_pkt_cnt3", pkt_cnt, 16'd3);
        chk("half_req_total", req_seen, 377);
        chk("half_gap_min", gap_min, 376);
        chk("half_gap_max", gap_max, 376);

        // Mid-packet rate change waits for the packet boundary
        rate_inc  = 24'h400000;
        rate_load = 1'b1;
        tick_n(1);
        rate_load = 1'b0;
        chk("chg_pend_mid", rate_chg_pend, 1'b1);
        tick_n(372);
        chk("chg_last_req", ts_rd_req, 1'b1);
        chk("chg_last_nosync", ts_rd_sync, 1'b0);
        chk("chg_pend_last", rate_chg_pend, 1'b1);
        tick_n(1);
        chk("chg_pend_clr", rate_chg_pend, 1'b0);
        tick_n(1);
        chk("chg_no_old_req", ts_rd_req, 1'b0);
        tick_n(1);
        chk("chg_new_sync", ts_rd_sync, 1'b1);
        tick_n(4);
        chk("chg_byte1_req", ts_rd_req, 1'b1);
        chk("chg_byte1_nosync", ts_rd_sync, 1'b0);
        chk("chg_pkt_cnt4", pkt_cnt, 16'd4);

        // Stop after byte 50: the remaining 137 bytes drain out
        tick_n(196);
        chk("drn_byte50_req", ts_rd_req, 1'b1);
        sched_en = 1'b0;
        tick_n(1);
        chk("drn_busy", sched_busy, 1'b1);
        mon_clear();
        tick_n(547);
        chk("drn_last_req", ts_rd_req, 1'b1);
        chk("drn_last_busy", sched_busy, 1'b1);
        tick_n(1);
        chk("drn_done_busy", sched_busy, 1'b0);
        tick_n(40);
        chk("drn_req_total", req_seen, 137);
        chk("drn_idle_req", ts_rd_req, 1'b0);
        chk("drn_idle_busy", sched_busy, 1'b0);
        chk("drn_pkt_cnt", pkt_cnt, 16'd4);

        // Restart, then reset at byte 100 of the packet
        sched_en = 1'b1;
        tick_n(5);
        chk("rs_restart_sync", ts_rd_sync, 1'b1);
        chk("rs_restart_cnt", pkt_cnt, 16'd4);
        tick_n(400);
        chk("rs_byte100_req", ts_rd_req, 1'b1);
        chk("rs_byte100_cnt", pkt_cnt, 16'd5);
        rst_125m = 1'b0;
        tick_n(1);
        chk("rs_req0", ts_rd_req, 1'b0);
        chk("rs_sync0", ts_rd_sync, 1'b0);
        chk("rs_busy0", sched_busy, 1'b0);
        chk("rs_pkt_cnt0", pkt_cnt, 16'd0);
        chk("rs_pend0", rate_chg_pend, 1'b0);
        rst_125m  = 1'b1;
        rate_inc  = 24'h400000;
        rate_load = 1'b1;
        tick_n(1);
        rate_load = 1'b0;
        chk("rs_reload_pend", rate_chg_pend, 1'b1);
        tick_n(5);
        chk("rs_first_sync", ts_rd_sync, 1'b1);
        chk("rs_first_cnt", pkt_cnt, 16'd0);
        tick_n(1);
        chk("rs_cnt1", pkt_cnt, 16'd1);

        // One request per 16 cycles
        do_reset();
        rst_125m  = 1'b1;
        rate_inc  = 24'h100000;
        rate_load = 1'b1;
        sched_en  = 1'b1;
        tick_n(1);
        rate_load = 1'b0;
        tick_n(16);
        chk("r16_before", ts_rd_req, 1'b0);
        tick_n(1);
        chk("r16_first_req", ts_rd_req, 1'b1);
        chk("r16_first_sync", ts_rd_sync, 1'b1);
        tick_n(15);
        chk("r16_gap", ts_rd_req, 1'b0);
        tick_n(1);
        chk("r16_second_req", ts_rd_req, 1'b1);
        chk("r16_second_nosync", ts_rd_sync, 1'b0);

        // Near-full rate for 10000 cycles
        do_reset();
        rst_125m  = 1'b1;
        rate_inc  = 24'hFFFFFF;
        rate_load = 1'b1;
        sched_en  = 1'b1;
        tick_n(1);
        rate_load = 1'b0;
        tick_n(5);
        mon_clear();
        tick_n(10000);
        chk("full_req_count", (req_seen == 9999 || req_seen == 10000), 1'b1);
        chk("full_gap_min", (gap_min >= 187 && gap_min <= 189), 1'b1);
        chk("full_gap_max", (gap_max >= 187 && gap_max <= 189), 1'b1);
        chk("full_sync_count", (sync_seen == 53 || sync_seen == 54), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
